regfile_zq: RTL and testbench
=============================

Name: regfile_zq

Overview:
- Parametrised successor to the coprocessor's general register file.
- Configurable data width, depth and read-port count.
- Adds same-cycle write-to-read bypass, an optional hardwired zero register and a hardware zeroize sequencer that wipes key material one register per cycle.
- Sits between the decode/issue stage (read/write ports) and the crypto control unit, which issues zeroize on key-erase commands.

Parameters:
DATA_W, 32, register width in bits
DEPTH, 32, number of registers; must be a power of two, at least 2
ADDR_W, 5, address width; must equal log2(DEPTH)
NUM_RD, 3, number of combinational read ports (1..8)
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
BYPASS, 1, 1 = a read of the address being written this cycle returns wr_data

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 = reset, sampled on rising edge of clk)
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W]; combinational
zeroize_req  input  1  request full wipe; level sampled each cycle
zeroize_busy  output  1  high while the sweep is in progress
zeroize_done  output  1  one-cycle pulse when the sweep completes
wr_err  output  1  one-cycle pulse, registered, the cycle after a write was dropped

Behaviour:
- Reset (rst==0 at a clk edge):
  - All DEPTH registers cleared to 0.
  - FSM goes to IDLE; sweep counter set to 0.
  - zeroize_busy=0, zeroize_done=0, wr_err=0.
  - Reset overrides every other input, including mid-sweep: the sweep aborts and no done pulse is issued.
- Write:
  - When wr_en=1, FSM in IDLE and zeroize_req=0, reg[wr_addr] <= wr_data at the edge.
  - When ZERO_REG=1 and wr_addr==0, the write is silently discarded; wr_err does not fire.
- Read: purely combinational, per port k, priority order:
  1. zeroize_busy=1 -> 0.
  2. ZERO_REG=1 and address==0 -> 0.
  3. BYPASS=1, wr_en=1, the write will be accepted this cycle, and wr_addr==rd_addr[k] -> wr_data.
  4. Otherwise -> reg[rd_addr[k]].
- Zeroize FSM has three states:
  - IDLE: zeroize_req=1 -> SWEEP with counter=0; any write in the same cycle is dropped.
  - SWEEP: each cycle reg[counter] <= 0 and counter increments. zeroize_busy=1. When counter==DEPTH-1, that register is cleared and the FSM moves to DONE.
  - DONE: zeroize_done=1 for exactly one cycle, then IDLE. zeroize_busy=0.
- Zeroize timing:
  - busy asserts the edge after the req is sampled and stays high for exactly DEPTH cycles.
  - done pulses on the following cycle.
  - A new req is accepted in IDLE only; req held high in DONE starts a new sweep the cycle after the return to IDLE.
  - Req in SWEEP or DONE is ignored.
- Dropped writes: wr_en=1 while in SWEEP or DONE, or coincident with an accepted zeroize_req -> register unchanged, wr_err=1 on the next cycle.
- Counter is ADDR_W bits; no wrap occurs inside a sweep because termination is on DEPTH-1.
- Simultaneous reads of the same address on several ports are always legal and return identical data.

Test Plan:
1. Write/readback: reset; write 0xDEADBEEF to r5 and 0x12345678 to r31; set rd_addr = {31,5,0} -> rd_data = {0x12345678, 0xDEADBEEF, 0}.
2. Bypass: r7 holds 0xAAAA0000; in the same cycle wr_en=1, wr_addr=7, wr_data=0x5555FFFF, rd_addr0=7 -> rd_data0=0x5555FFFF that cycle. With BYPASS=0 the port reads 0xAAAA0000 that cycle and 0x5555FFFF the next.
3. Zero register: write 0xFFFFFFFF to r0 -> reads 0 and wr_err stays 0. Repeat with ZERO_REG=0 -> reads 0xFFFFFFFF.
4. Zeroize: fill all 32 regs with nonzero values; pulse zeroize_req -> busy high for exactly 32 cycles, reads return 0 throughout, done pulses once on cycle 33 after req, and afterwards every register reads 0.
5. Write during sweep: at sweep cycle 10, write 0x1 to r31 -> wr_err pulses next cycle and r31 reads 0 after done. Write coincident with req -> dropped, wr_err=1.
6. Reset mid-sweep: drive rst=0 at sweep cycle 12 -> next cycle busy=0, all regs 0, no done pulse. Then a normal write to r3 of 0xCAFE succeeds.

Source files
------------

// File: rtl/regfile_zq.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_zq
//  Brief    : Parametrised general register file with multiple combinational
//             read ports, same-cycle write-to-read bypass, an optional
//             hardwired zero register and a one-register-per-cycle zeroize
//             sweep for key-material erasure.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_zq #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 3,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   input  logic                       zeroize_req,
   output logic                       zeroize_busy,
   output logic                       zeroize_done,
   output logic                       wr_err
);

   localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                wr_err_q, wr_err_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                w_zero_accept;
   logic                w_wr_ok;
   logic                w_wr_accept;
   logic                w_addr_is_zero;

   // A write is only honoured in IDLE when no wipe is being started; writes
   // to the hardwired zero register are discarded without raising an error.
   always_comb begin
      w_zero_accept  = (state_q == ST_IDLE) && zeroize_req;
      w_wr_ok        = wr_en && (state_q == ST_IDLE) && !zeroize_req;
      w_addr_is_zero = (ZERO_REG != 0) && (wr_addr == '0);
      w_wr_accept    = w_wr_ok && !w_addr_is_zero;
      wr_err_d       = wr_en && !w_wr_ok;
   end

   // Zeroize sequencer next-state: IDLE -> SWEEP (DEPTH cycles) -> DONE -> IDLE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (w_zero_accept) begin
               state_d = ST_SWEEP;
               cnt_d   = '0;
            end
         end
         ST_SWEEP: begin
            if (cnt_q == c_last_idx) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Sequencer state, sweep counter and the registered dropped-write pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         wr_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wr_err_q <= wr_err_d;
      end
   end

   // Register storage: the sweep owns the array while active, otherwise the
   // write port updates it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (state_q == ST_SWEEP) begin
         mem_q[cnt_q] <= '0;
      end else if (w_wr_accept) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign zeroize_busy = (state_q == ST_SWEEP);
   assign zeroize_done = (state_q == ST_DONE);
   assign wr_err       = wr_err_q;

   generate
      for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
         logic [ADDR_W-1:0] w_addr;
         logic [DATA_W-1:0] w_data;

         assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

         // Read mux: a wipe in progress hides all contents, then the zero
         // register, then the bypass of the write accepted this cycle.
         always_comb begin
            w_data = mem_q[w_addr];
            if (zeroize_busy) begin
               w_data = '0;
            end else if ((ZERO_REG != 0) && (w_addr == '0)) begin
               w_data = '0;
            end else if ((BYPASS != 0) && w_wr_accept && (wr_addr == w_addr)) begin
               w_data = wr_data;
            end
         end

         assign rd_data[k*DATA_W +: DATA_W] = w_data;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_zq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_zq
//  Brief    : Directed self-checking bench for regfile_zq. A default instance
//             (bypass + zero register) and a variant without either share
//             the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_zq;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic [NR*AW-1:0] rd_addr;
   logic            zeroize_req;

   logic [NR*DW-1:0] rd_data_a, rd_data_b;
   logic            busy_a, done_a, err_a;
   logic            busy_b, done_b, err_b;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc;
   int busy_cnt;

   always #5 clk = ~clk;

   regfile_zq #(
      .DATA_W(DW), .DEPTH(32), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)
   ) dut_a (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data_a), .zeroize_req(zeroize_req),
      .zeroize_busy(busy_a), .zeroize_done(done_a), .wr_err(err_a)
   );

   regfile_zq #(
      .DATA_W(DW), .DEPTH(32), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0), .BYPASS(0)
   ) dut_b (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data_b), .zeroize_req(zeroize_req),
      .zeroize_busy(busy_b), .zeroize_done(done_b), .wr_err(err_b)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   initial begin
      rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr = '0; zeroize_req = 1'b0;
      tick(); tick();
      rst = 1'b1;
      rd_addr = {5'd3, 5'd2, 5'd1};
      #1;
      check_val("rst_busy", {31'd0, busy_a}, 32'd0);
      check_val("rst_done", {31'd0, done_a}, 32'd0);
      check_val("rst_err",  {31'd0, err_a},  32'd0);
      check_val("rst_rd1",  rd_data_a[0 +: 32], 32'd0);
      check_val("rst_rd3",  rd_data_a[64 +: 32], 32'd0);

      // Write / readback
      wr(5'd5, 32'hDEADBEEF);
      wr(5'd31, 32'h12345678);
      rd_addr = {5'd31, 5'd5, 5'd0};
      #1;
      check_val("wb_p0", rd_data_a[0 +: 32],  32'h0);
      check_val("wb_p1", rd_data_a[32 +: 32], 32'hDEADBEEF);
      check_val("wb_p2", rd_data_a[64 +: 32], 32'h12345678);

      // Bypass
      wr(5'd7, 32'hAAAA0000);
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h5555FFFF;
      rd_addr = {5'd0, 5'd7, 5'd7};
      #1;
      check_val("byp_p0",   rd_data_a[0 +: 32],  32'h5555FFFF);
      check_val("byp_p1",   rd_data_a[32 +: 32], 32'h5555FFFF);
      check_val("nobyp_p0", rd_data_b[0 +: 32],  32'hAAAA0000);
      tick();
      wr_en = 1'b0;
      #1;
      check_val("nobyp_nxt", rd_data_b[0 +: 32], 32'h5555FFFF);

      // Zero register
      wr(5'd0, 32'hFFFFFFFF);
      rd_addr = {5'd0, 5'd0, 5'd0};
      #1;
      check_val("z_err", {31'd0, err_a}, 32'd0);
      check_val("z_rd",  rd_data_a[0 +: 32], 32'h0);
      check_val("nz_rd", rd_data_b[0 +: 32], 32'hFFFFFFFF);

      // Zeroize with a dropped write at sweep cycle 10
      for (int i = 0; i < 32; i++) wr(AW'(i), 32'hA5000000 | 32'(i));
      rd_addr = {5'd5, 5'd17, 5'd31};
      zeroize_req = 1'b1;
      tick();
      zeroize_req = 1'b0;
      busy_cnt = 0;
      cyc = 0;
      while (busy_a && cyc < 40) begin
         check_val("sw_rd", rd_data_a[0 +: 32], 32'h0);
         if (cyc == 11) check_val("sw_err", {31'd0, err_a}, 32'd1);
         if (cyc == 10) begin
            wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h1;
         end
         busy_cnt++;
         tick();
         wr_en = 1'b0;
         cyc++;
      end
      check_val("sw_len",    32'(busy_cnt), 32'd32);
      check_val("sw_done",   {31'd0, done_a}, 32'd1);
      tick();
      check_val("sw_done_1", {31'd0, done_a}, 32'd0);
      for (int i = 0; i < 32; i++) begin
         rd_addr = {5'd0, 5'd0, AW'(i)};
         #1;
         check_val($sformatf("wipe_a%0d", i), rd_data_a[0 +: 32], 32'h0);
         check_val($sformatf("wipe_b%0d", i), rd_data_b[0 +: 32], 32'h0);
      end

      // Write coincident with an accepted request is dropped
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
      zeroize_req = 1'b1;
      tick();
      wr_en = 1'b0; zeroize_req = 1'b0;
      check_val("co_err",  {31'd0, err_a},  32'd1);
      check_val("co_busy", {31'd0, busy_a}, 32'd1);
      cyc = 0;
      while (!done_a && cyc < 50) begin
         tick();
         cyc++;
      end
      check_val("co_done", {31'd0, done_a}, 32'd1);
      tick();

      // Reset mid-sweep
      wr(5'd20, 32'h2020);
      zeroize_req = 1'b1;
      tick();
      zeroize_req = 1'b0;
      check_val("rs_busy0", {31'd0, busy_a}, 32'd1);
      repeat (12) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check_val("rs_busy", {31'd0, busy_a}, 32'd0);
      check_val("rs_done", {31'd0, done_a}, 32'd0);
      rd_addr = {5'd0, 5'd0, 5'd20};
      #1;
      check_val("rs_r20", rd_data_a[0 +: 32], 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("rs_nodone", {31'd0, done_a}, 32'd0);
      end
      wr(5'd3, 32'h0000CAFE);
      rd_addr = {5'd0, 5'd0, 5'd3};
      #1;
      check_val("rs_wr3", rd_data_a[0 +: 32], 32'h0000CAFE);
      check_val("rs_err", {31'd0, err_a}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
